debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_sync.sv | 116 +++++++++++
 tb/tb_debounce_sync.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer plus counting debouncer.
// Produces a registered level, its complement and edge pulses.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic q_bar,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  logic          sync1_q;
  logic          sync2_q;
  logic          d_sync;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          q_bar_q, q_bar_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  assign d_sync = sync2_q;

  // Next-state logic: count agreeing samples, restart on any reversal.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (d_sync) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!d_sync) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!d_sync) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (d_sync) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        q_d     = 1'b0;
      end
    endcase
    q_bar_d = ~q_d;
  end

  // Synchronizer, FSM state and registered outputs; reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      q_bar_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      q_bar_q <= q_bar_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q     = q_q;
  assign q_bar = q_bar_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: run-length reference model, directed and
// randomized stimulus, per-cycle compare on the falling edge.
module tb_debounce_sync;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d = 1'b0;
  logic q, q_bar, rise, fall;

  int checks = 0;
  int errors = 0;

  debounce_sync #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
    .d(d),
    .q(q),
    .q_bar(q_bar),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;

  // Reference: d delayed two edges, then a run of samples that
  // disagree with q must reach DC in a row to flip q.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_q = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  int   m_run = 0;
  bit   m_ok = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_q = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_run = 0;
        m_ok = 1'b1;
      end else begin
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (m_s2 != m_q) begin
          m_run = m_run + 1;
          if (m_run == DC) begin
            m_q = ~m_q;
            m_rise = m_q;
            m_fall = ~m_q;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = d;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        checks++;
        if ({q, q_bar, rise, fall} !== {m_q, ~m_q, m_rise, m_fall}) begin
          errors++;
          $display("FAIL model t=%0t got q/qb/r/f=%b%b%b%b want %b%b%b%b",
                   $time, q, q_bar, rise, fall,
                   m_q, ~m_q, m_rise, m_fall);
        end
        checks++;
        if (rise && fall) begin
          errors++;
          $display("FAIL both_pulses t=%0t got rise=%b fall=%b want not both",
                   $time, rise, fall);
        end
      end
    end
  end

  task automatic cyc(input logic dv, input logic rv);
    d = dv;
    reset = rv;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic eq, input logic er,
                     input logic ef);
    checks++;
    if ({q, q_bar, rise, fall} !== {eq, ~eq, er, ef}) begin
      errors++;
      $display("FAIL %s t=%0t got q/qb/r/f=%b%b%b%b want %b%b%b%b",
               nm, $time, q, q_bar, rise, fall, eq, ~eq, er, ef);
    end
  endtask

  initial begin
    logic v;
    int   hold;
    bit   rr;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      chk("reset_hold", 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk("idle_low", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i <= 6; i++) begin
      cyc(1'b1, 1'b0);
      chk("rise_latency", 1'(i >= 5), 1'(i == 5), 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      cyc(1'(i % 2 == 0), 1'b0);
      chk("toggle_hi", 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);

    for (int i = 0; i <= 6; i++) begin
      cyc(1'b0, 1'b0);
      chk("fall_latency", 1'(i < 5), 1'b0, 1'(i == 5));
    end

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      chk("short_run", 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0);
      chk("short_run_after", 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      cyc(1'(i % 2 == 0), 1'b0);
      chk("toggle_lo", 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("mid_reset", 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0);
      chk("after_reset", 1'(i >= 6), 1'(i == 6), 1'b0);
    end

    for (int n = 0; n < 500; n++) begin
      v = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 7);
      rr = ($urandom_range(0, 40) == 0);
      for (int j = 0; j < hold; j++) begin
        cyc(v, 1'(rr && j == 0));
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
